if_fetch_ctrl: RTL and testbench

- Sequencer for the fetch-stage PC register and the instruction SRAM-like bus.
- Issues one fetch at a time at the current PC and drives the PC's enable and redirect selects.
- Latches branch and exception redirects from later stages and squashes wrong-path responses.
- Presents fetched instructions to decode through a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 44 ++++
 rtl/if_redirect_latch.sv | 43 ++++
 rtl/if_fetch_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, redirect payload, reset vector and
// the redirect priority/overwrite helper.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    OUT   = 2'd2,
    REDIR = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic            is_exception;
    logic [XLEN-1:0] target;
  } redirect_t;

  // Exception wins over branch; a branch may replace a branch but never an exception.
  function automatic redirect_t redirect_merge(
    input redirect_t       held,
    input logic            br_req,
    input logic [XLEN-1:0] br_target,
    input logic            ex_req,
    input logic [XLEN-1:0] ex_vector
  );
    redirect_t r;
    r = held;
    if (ex_req) begin
      r.valid        = 1'b1;
      r.is_exception = 1'b1;
      r.target       = ex_vector;
    end else if (br_req && !(held.valid && held.is_exception)) begin
      r.valid        = 1'b1;
      r.is_exception = 1'b0;
      r.target       = br_target;
    end
    return r;
  endfunction

endpackage

// File: rtl/if_redirect_latch.sv
// Pending-redirect holder: merges incoming branch/exception pulses with the
// stored request and clears on the consume strobe.
module if_redirect_latch
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_branch_req,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_exception_req,
  input  logic [XLEN-1:0] i_exception_vector,
  output logic            o_pend_now,
  output redirect_t       o_merged,
  output redirect_t       o_pending
);

  redirect_t r_pending;
  redirect_t w_merged;
  redirect_t w_fresh;

  assign w_merged = redirect_merge(r_pending, i_branch_req, i_branch_target,
                                   i_exception_req, i_exception_vector);

  // On consume, only a request arriving in that same cycle survives.
  assign w_fresh  = redirect_merge('0, i_branch_req, i_branch_target,
                                   i_exception_req, i_exception_vector);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else if (i_clear) begin
      r_pending <= w_fresh;
    end else begin
      r_pending <= w_merged;
    end
  end

  assign o_pend_now = w_merged.valid;
  assign o_merged   = w_merged;
  assign o_pending  = r_pending;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: one outstanding instruction-bus read, PC strobes and
// redirect handling. IF_FETCH_TIMEOUT_EN adds the sticky WAIT timeout flag.
module if_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_address,
  output logic            pc_en,
  output logic            pc_branch_taken,
  output logic [XLEN-1:0] pc_branch_address,
  output logic            pc_exception_taken,
  output logic [XLEN-1:0] pc_exception_address,
  input  logic            branch_req,
  input  logic [XLEN-1:0] branch_target,
  input  logic            exception_req,
  input  logic [XLEN-1:0] exception_vector,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_addr_ok,
  input  logic            inst_data_ok,
  input  logic [XLEN-1:0] inst_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  output logic            if_adel,
  input  logic            id_ready,
  output logic            fetch_timeout
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_req_pc;
  logic            r_discard;
  logic            r_pc_en;
  logic            r_pc_branch_taken;
  logic            r_pc_exception_taken;
  logic            r_if_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_inst;
  logic            r_if_adel;

  logic            w_pend_now;
  logic            w_aligned;
  logic            w_clear;
  logic            w_req_fire;
  redirect_t       w_merged;
  redirect_t       w_pending;
  logic            w_unused;

  if_redirect_latch u_redirect_latch (
    .clk                (clk),
    .rst                (rst),
    .i_clear            (w_clear),
    .i_branch_req       (branch_req),
    .i_branch_target    (branch_target),
    .i_exception_req    (exception_req),
    .i_exception_vector (exception_vector),
    .o_pend_now         (w_pend_now),
    .o_merged           (w_merged),
    .o_pending          (w_pending)
  );

  assign w_aligned  = (pc_address[1:0] == 2'b00);
  assign w_clear    = (r_state == REDIR);
  assign w_req_fire = (r_state == REQ) && w_aligned && inst_addr_ok;

  // Request is a decode of the state register; the PC cannot move while in REQ.
  assign inst_req  = !rst && (r_state == REQ) && w_aligned;
  assign inst_addr = inst_req ? pc_address : '0;

  // Targets follow the pending register; it equals the consumed target in REDIR.
  assign pc_branch_address    = w_pending.target;
  assign pc_exception_address = w_pending.target;

  assign pc_en              = r_pc_en;
  assign pc_branch_taken    = r_pc_branch_taken;
  assign pc_exception_taken = r_pc_exception_taken;
  assign if_valid           = r_if_valid;
  assign if_pc              = r_if_pc;
  assign if_inst            = r_if_inst;
  assign if_adel            = r_if_adel;

  assign w_unused = ^{w_merged.valid, w_merged.target,
                      w_pending.valid, w_pending.is_exception};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state              <= REQ;
      r_req_pc             <= '0;
      r_discard            <= 1'b0;
      r_pc_en              <= 1'b0;
      r_pc_branch_taken    <= 1'b0;
      r_pc_exception_taken <= 1'b0;
      r_if_valid           <= 1'b0;
      r_if_pc              <= '0;
      r_if_inst            <= '0;
      r_if_adel            <= 1'b0;
    end else begin
      r_pc_en              <= 1'b0;
      r_pc_branch_taken    <= 1'b0;
      r_pc_exception_taken <= 1'b0;

      case (r_state)
        REQ: begin
          if (!w_aligned) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= pc_address;
            r_if_inst  <= '0;
            r_if_adel  <= 1'b1;
            r_state    <= OUT;
          end else if (inst_addr_ok) begin
            r_req_pc <= pc_address;
            r_state  <= WAIT;
            if (w_pend_now) begin
              r_discard <= 1'b1;
            end else begin
              r_pc_en <= 1'b1;
            end
          end
        end

        WAIT: begin
          if (inst_data_ok) begin
            if (r_discard || w_pend_now) begin
              r_discard            <= 1'b0;
              r_state              <= REDIR;
              r_pc_en              <= 1'b1;
              r_pc_exception_taken <= w_merged.is_exception;
              r_pc_branch_taken    <= !w_merged.is_exception;
            end else begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_req_pc;
              r_if_inst  <= inst_rdata;
              r_if_adel  <= 1'b0;
              r_state    <= OUT;
            end
          end
        end

        OUT: begin
          // A redirect squashes the slot even when decode is ready.
          if (w_pend_now) begin
            r_if_valid           <= 1'b0;
            r_state              <= REDIR;
            r_pc_en              <= 1'b1;
            r_pc_exception_taken <= w_merged.is_exception;
            r_pc_branch_taken    <= !w_merged.is_exception;
          end else if (id_ready) begin
            r_if_valid <= 1'b0;
            r_state    <= REQ;
          end
        end

        REDIR: begin
          r_state <= REQ;
        end

        default: begin
          r_state <= REQ;
        end
      endcase
    end
  end

`ifdef IF_FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_fetch_timeout;

  // Counts WAIT cycles since entry; flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt      <= '0;
      r_fetch_timeout <= 1'b0;
    end else if (w_req_fire) begin
      r_wait_cnt <= '0;
    end else if (r_state == WAIT) begin
      if (r_wait_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
      if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        r_fetch_timeout <= 1'b1;
      end
    end
  end

  assign fetch_timeout = r_fetch_timeout;
`else
  logic [31:0] w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign fetch_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a PC-register model, a zero-wait
// memory model and an expected-delivery queue.
module tb_if_fetch_ctrl;
  import fetch_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } exp_t;

`ifdef IF_FETCH_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] pc_address;
  logic        pc_en;
  logic        pc_branch_taken;
  logic [31:0] pc_branch_address;
  logic        pc_exception_taken;
  logic [31:0] pc_exception_address;
  logic        branch_req;
  logic [31:0] branch_target;
  logic        exception_req;
  logic [31:0] exception_vector;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;
  logic        id_ready;
  logic        fetch_timeout;

  logic [31:0] tb_pc;
  logic        mem_hold;
  logic        m_pend;
  logic [31:0] m_addr;
  int          n_acc;
  int          n_pc_en;
  int          n_vec;
  int          n_err;
  exp_t        sb[$];

  if_fetch_ctrl #(.TIMEOUT_CYCLES(10)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .pc_address           (pc_address),
    .pc_en                (pc_en),
    .pc_branch_taken      (pc_branch_taken),
    .pc_branch_address    (pc_branch_address),
    .pc_exception_taken   (pc_exception_taken),
    .pc_exception_address (pc_exception_address),
    .branch_req           (branch_req),
    .branch_target        (branch_target),
    .exception_req        (exception_req),
    .exception_vector     (exception_vector),
    .inst_req             (inst_req),
    .inst_addr            (inst_addr),
    .inst_addr_ok         (inst_addr_ok),
    .inst_data_ok         (inst_data_ok),
    .inst_rdata           (inst_rdata),
    .if_valid             (if_valid),
    .if_pc                (if_pc),
    .if_inst              (if_inst),
    .if_adel              (if_adel),
    .id_ready             (id_ready),
    .fetch_timeout        (fetch_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2400_0001 + (a - RESET_VECTOR);
  endfunction

  // PC register model
  always @(posedge clk) begin
    if (rst) tb_pc <= RESET_VECTOR;
    else if (pc_en) begin
      if (pc_exception_taken)   tb_pc <= pc_exception_address;
      else if (pc_branch_taken) tb_pc <= pc_branch_address;
      else                      tb_pc <= tb_pc + 32'd4;
    end
  end
  assign pc_address = tb_pc;

  // Zero-wait memory: accept immediately, answer next cycle unless held
  assign inst_addr_ok = inst_req;
  assign inst_data_ok = m_pend && !mem_hold;
  assign inst_rdata   = mem_word(m_addr);

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_addr <= '0;
    end else begin
      if (inst_data_ok) m_pend <= 1'b0;
      if (inst_req && inst_addr_ok) begin
        m_pend <= 1'b1;
        m_addr <= inst_addr;
        n_acc  <= n_acc + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && pc_en) n_pc_en <= n_pc_en + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst, input logic adel);
    exp_t e;
    e.pc = pc; e.inst = inst; e.adel = adel;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    while (!if_valid && k < budget) begin
      tick();
      k++;
    end
    chk1(tag, if_valid, 1'b1);
  endtask

  // Compare the presented slot with the queue head, then hand it to decode
  task automatic deliver(input string tag);
    exp_t e;
    wait_valid({tag, "_valid"}, 20);
    if (sb.size() == 0) begin
      chk1({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk32({tag, "_pc"}, if_pc, e.pc);
      chk32({tag, "_inst"}, if_inst, e.inst);
      chk1({tag, "_adel"}, if_adel, e.adel);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
  endtask

  initial begin
    int pe;
    int acc;
    exp_t e;
    n_vec = 0; n_err = 0; n_acc = 0; n_pc_en = 0;
    rst = 1'b1; id_ready = 1'b1; mem_hold = 1'b0;
    branch_req = 1'b0; branch_target = '0;
    exception_req = 1'b0; exception_vector = '0;
    repeat (3) tick();

    // Reset state
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_pc_en", pc_en, 1'b0);
    chk1("rst_inst_req", inst_req, 1'b0);
    chk1("rst_br_sel", pc_branch_taken, 1'b0);
    chk1("rst_exc_sel", pc_exception_taken, 1'b0);
    chk32("rst_if_pc", if_pc, 32'h0);
    chk32("rst_br_addr", pc_branch_address, 32'h0);
    chk1("rst_timeout", fetch_timeout, 1'b0);

    // First fetch at the reset vector, zero-wait memory
    rst = 1'b0;
    push_exp(RESET_VECTOR, 32'h2400_0001, 1'b0);
    pe = n_pc_en;
    #1;
    chk1("t1_inst_req", inst_req, 1'b1);
    chk32("t1_inst_addr", inst_addr, RESET_VECTOR);
    tick();
    chk1("t1_valid_early", if_valid, 1'b0);
    chk1("t1_pc_en", pc_en, 1'b1);
    chk1("t1_br_sel", pc_branch_taken, 1'b0);
    chk1("t1_exc_sel", pc_exception_taken, 1'b0);
    tick();
    chk1("t1_valid", if_valid, 1'b1);
    e = sb.pop_front();
    chk32("t1_if_pc", if_pc, e.pc);
    chk32("t1_if_inst", if_inst, e.inst);
    chk1("t1_if_adel", if_adel, e.adel);
    chk32("t1_pc_en_pulses", 32'(n_pc_en - pe), 32'd1);
    tick();
    id_ready = 1'b0;

    // Branch while WAIT: response dropped, redirect to 0xbfc00100
    tick();
    branch_req = 1'b1; branch_target = 32'hbfc0_0100;
    tick();
    branch_req = 1'b0;
    chk1("t2_valid_dropped", if_valid, 1'b0);
    chk1("t2_pc_en", pc_en, 1'b1);
    chk1("t2_br_sel", pc_branch_taken, 1'b1);
    chk1("t2_exc_sel", pc_exception_taken, 1'b0);
    chk32("t2_br_addr", pc_branch_address, 32'hbfc0_0100);
    tick();
    chk1("t2_inst_req", inst_req, 1'b1);
    chk32("t2_inst_addr", inst_addr, 32'hbfc0_0100);
    chk1("t2_valid_after", if_valid, 1'b0);
    push_exp(32'hbfc0_0100, mem_word(32'hbfc0_0100), 1'b0);
    deliver("t2");

    // Simultaneous branch+exception in REQ, then a later branch
    pe = n_pc_en;
    branch_req = 1'b1; branch_target = 32'hbfc0_0040;
    exception_req = 1'b1; exception_vector = 32'hbfc0_0380;
    tick();
    exception_req = 1'b0;
    branch_req = 1'b1; branch_target = 32'hbfc0_0080;
    tick();
    branch_req = 1'b0;
    chk32("t3_no_advance", 32'(n_pc_en - pe), 32'd0);
    chk1("t3_pc_en", pc_en, 1'b1);
    chk1("t3_exc_sel", pc_exception_taken, 1'b1);
    chk1("t3_br_sel", pc_branch_taken, 1'b0);
    chk32("t3_exc_addr", pc_exception_address, 32'hbfc0_0380);
    chk1("t3_valid", if_valid, 1'b0);
    tick();
    chk32("t3_inst_addr", inst_addr, 32'hbfc0_0380);
    push_exp(32'hbfc0_0380, mem_word(32'hbfc0_0380), 1'b0);
    deliver("t3");

    // Decode stalls five cycles: payload holds, no new request
    push_exp(32'hbfc0_0384, mem_word(32'hbfc0_0384), 1'b0);
    wait_valid("t5_valid", 20);
    acc = n_acc;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("t5_valid_hold", if_valid, 1'b1);
      chk32("t5_pc_hold", if_pc, 32'hbfc0_0384);
      chk32("t5_inst_hold", if_inst, mem_word(32'hbfc0_0384));
      chk1("t5_no_req", inst_req, 1'b0);
    end
    chk32("t5_no_accept", 32'(n_acc - acc), 32'd0);
    deliver("t5");

    // Misaligned PC: branch squashes the held slot, then address-error slot
    wait_valid("t4_slot", 20);
    branch_req = 1'b1; branch_target = 32'hbfc0_0002;
    tick();
    branch_req = 1'b0;
    chk1("t4_squash", if_valid, 1'b0);
    chk1("t4_br_sel", pc_branch_taken, 1'b1);
    tick();
    chk1("t4_no_req", inst_req, 1'b0);
    pe = n_pc_en; acc = n_acc;
    push_exp(32'hbfc0_0002, 32'h0, 1'b1);
    deliver("t4");
    chk32("t4_no_pc_en", 32'(n_pc_en - pe), 32'd0);
    chk32("t4_no_accept", 32'(n_acc - acc), 32'd0);

    // Exception recovers from the misaligned PC
    wait_valid("t4r_slot", 20);
    exception_req = 1'b1; exception_vector = 32'hbfc0_0380;
    tick();
    exception_req = 1'b0;
    chk1("t4r_exc_sel", pc_exception_taken, 1'b1);
    chk1("t4r_br_sel", pc_branch_taken, 1'b0);
    chk1("t4r_squash", if_valid, 1'b0);
    tick();
    chk1("t4r_inst_req", inst_req, 1'b1);
    chk32("t4r_inst_addr", inst_addr, 32'hbfc0_0380);
    push_exp(32'hbfc0_0380, mem_word(32'hbfc0_0380), 1'b0);
    deliver("t4r");

    // Memory withholds data: timeout after ten WAIT cycles when built in
    mem_hold = 1'b1;
    repeat (10) tick();
    chk1("t6_timeout_early", fetch_timeout, 1'b0);
    chk1("t6_single_outstanding", inst_req, 1'b0);
    chk1("t6_no_valid", if_valid, 1'b0);
    tick();
    chk1("t6_timeout_set", fetch_timeout, TO_EN);
    repeat (3) tick();
    chk1("t6_timeout_hold", fetch_timeout, TO_EN);
    mem_hold = 1'b0;
    push_exp(32'hbfc0_0384, mem_word(32'hbfc0_0384), 1'b0);
    deliver("t6");
    chk1("t6_timeout_sticky", fetch_timeout, TO_EN);

    // Reset in the middle of a transaction
    mem_hold = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk1("t7_valid", if_valid, 1'b0);
    chk1("t7_inst_req", inst_req, 1'b0);
    chk1("t7_pc_en", pc_en, 1'b0);
    chk1("t7_timeout", fetch_timeout, 1'b0);
    mem_hold = 1'b0;
    rst = 1'b0;
    push_exp(RESET_VECTOR, 32'h2400_0001, 1'b0);
    deliver("t7");
    chk32("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
